// File: rtl/cpu_pkg.sv
// Shared datapath constants and types for decode, the register file and the ALU.
package cpu_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage : cpu_pkg

// File: rtl/registers_if.sv
// Register-file access bus: two read ports and one write port between decode/writeback and storage.
interface registers_if;
  import cpu_pkg::*;

  reg_idx_t read_reg1;
  reg_idx_t read_reg2;
  reg_idx_t write_reg;
  word_t    write_data;
  logic     reg_write;
  word_t    read_data1;
  word_t    read_data2;

  modport master (
    output read_reg1,
    output read_reg2,
    output write_reg,
    output write_data,
    output reg_write,
    input  read_data1,
    input  read_data2
  );

  modport slave (
    input  read_reg1,
    input  read_reg2,
    input  write_reg,
    input  write_data,
    input  reg_write,
    output read_data1,
    output read_data2
  );

endinterface : registers_if

// File: rtl/registers.sv
// 16 x 16-bit general-purpose register file: one synchronous write port, two combinational
// read ports, asynchronous clear. Register 0 is an ordinary writable register.
module registers
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  registers_if.slave  bus
);

  word_t regs_q [NUM_REGS];
  word_t regs_d [NUM_REGS];

  // Next-state: only the addressed register takes write_data, and only when enabled.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.reg_write && (bus.write_reg == reg_idx_t'(i))) begin
        regs_d[i] = bus.write_data;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Register storage with asynchronous clear to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // No write-through bypass: a same-cycle write shows up only after the edge.
  assign bus.read_data1 = regs_q[bus.read_reg1];
  assign bus.read_data2 = regs_q[bus.read_reg2];

endmodule : registers

// File: tb/tb_registers.sv
// Self-checking bench for the register file: directed scenarios plus randomized traffic
// checked against an array reference model.
module tb_registers;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic [15:0] model [16];

  registers_if bus ();

  registers dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Commit a write in the model exactly as the register-file rules say.
  task automatic write_cycle(input logic [3:0] idx, input logic [15:0] val, input logic en);
    bus.write_reg  = idx;
    bus.write_data = val;
    bus.reg_write  = en;
    tick();
    if (en && rst_n) model[idx] = val;
  endtask

  task automatic sweep_both(input string tag);
    bus.reg_write = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.read_reg1 = 4'(i);
      bus.read_reg2 = 4'(15 - i);
      #1;
      check_eq({tag, "_p1"}, bus.read_data1, model[i]);
      check_eq({tag, "_p2"}, bus.read_data2, model[15 - i]);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    rst_n          = 1'b0;
    bus.read_reg1  = 4'd0;
    bus.read_reg2  = 4'd0;
    bus.write_reg  = 4'd0;
    bus.write_data = 16'h0000;
    bus.reg_write  = 1'b0;

    // Reset state, including a write attempted while held in reset.
    tick();
    sweep_both("reset");
    write_cycle(4'd3, 16'hFFFF, 1'b1);
    bus.read_reg1 = 4'd3;
    #1;
    check_eq("write_in_reset", bus.read_data1, 16'h0000);

    // Release between edges; the first edge afterwards must accept a write.
    bus.reg_write = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) write_cycle(4'(i), 16'(i), 1'b1);
    sweep_both("fill");

    // Disabled writes leave everything alone.
    for (int k = 0; k < 3; k++) write_cycle(4'd5, 16'hBEEF, 1'b0);
    bus.read_reg1 = 4'd5;
    #1;
    check_eq("write_disable", bus.read_data1, 16'h0005);

    // Same-cycle read and write of register 7.
    bus.read_reg1  = 4'd7;
    bus.write_reg  = 4'd7;
    bus.write_data = 16'hA5A5;
    bus.reg_write  = 1'b1;
    #1;
    check_eq("rw_before_edge", bus.read_data1, 16'h0007);
    tick();
    model[7] = 16'hA5A5;
    check_eq("rw_after_edge", bus.read_data1, 16'hA5A5);

    // Dual port read of two freshly written registers.
    write_cycle(4'd3, 16'h1234, 1'b1);
    write_cycle(4'd15, 16'hFFFF, 1'b1);
    bus.reg_write = 1'b0;
    bus.read_reg1 = 4'd3;
    bus.read_reg2 = 4'd15;
    #1;
    check_eq("dual_p1", bus.read_data1, 16'h1234);
    check_eq("dual_p2", bus.read_data2, 16'hFFFF);

    // Random traffic: reads checked before each edge against the pre-edge model.
    for (int n = 0; n < 300; n++) begin
      bus.read_reg1  = 4'($urandom_range(0, 15));
      bus.read_reg2  = ($urandom_range(0, 3) == 0) ? bus.read_reg1 : 4'($urandom_range(0, 15));
      bus.write_reg  = ($urandom_range(0, 2) == 0) ? bus.read_reg1 : 4'($urandom_range(0, 15));
      bus.write_data = 16'($urandom);
      bus.reg_write  = ($urandom_range(0, 1) == 1);
      #1;
      check_eq("rand_p1", bus.read_data1, model[bus.read_reg1]);
      check_eq("rand_p2", bus.read_data2, model[bus.read_reg2]);
      tick();
      if (bus.reg_write) model[bus.write_reg] = bus.write_data;
    end
    bus.reg_write = 1'b0;
    sweep_both("rand_final");

    // Asynchronous reset dropped between edges clears everything at once.
    for (int i = 0; i < 16; i++) write_cycle(4'(i), 16'(16'h0100 + i), 1'b1);
    bus.reg_write = 1'b0;
    bus.read_reg1 = 4'd9;
    bus.read_reg2 = 4'd12;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_clr_p1", bus.read_data1, 16'h0000);
    check_eq("async_clr_p2", bus.read_data2, 16'h0000);
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    write_cycle(4'd9, 16'h1111, 1'b1);
    bus.reg_write = 1'b0;
    sweep_both("async_reset");

    // First write after release lands on the first rising edge.
    rst_n = 1'b1;
    write_cycle(4'd9, 16'h2222, 1'b1);
    bus.reg_write = 1'b0;
    bus.read_reg1 = 4'd9;
    #1;
    check_eq("post_reset_write", bus.read_data1, 16'h2222);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_registers

// File: doc/registers.md
# registers

General-purpose register file for the 16-bit CPU datapath: 16 registers of 16 bits, two combinational read ports and one synchronous write port. It sits between instruction decode, which supplies the register indices, and the ALU and writeback stages, which consume the operands and produce the write data. Reset clears every register to zero.

## Interface
Parameters:
- DATA_W, 16, width of each register and of the data ports.
- ADDR_W, 4, width of the register index; register count NUM_REGS = 2**ADDR_W = 16.

Ports:
- clk  input  1  single clock; all writes occur on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- read_reg1  input  ADDR_W  index for read port 1.
- read_reg2  input  ADDR_W  index for read port 2.
- write_reg  input  ADDR_W  index for the write port.
- write_data  input  DATA_W  value to write.
- reg_write  input  1  write enable, active-high.
- read_data1  output  DATA_W  contents of register read_reg1.
- read_data2  output  DATA_W  contents of register read_reg2.

## Operation
- Storage is 16 × 16-bit registers, indexed 0..15.
- All 16 registers are writable. Register 0 is not hardwired to zero.
- Write: on a rising clk edge, if reg_write is 1 and rst_n is 1, regs[write_reg] takes write_data. Other registers hold their values.
- When reg_write is 0, no register changes, whatever write_reg and write_data are.
- Read: read_data1 = regs[read_reg1] and read_data2 = regs[read_reg2]. Both are purely combinational from the index and the current register contents.
- Both read ports may address the same register, including the register being written. Each port returns the same value independently.
- Reset: while rst_n is 0, every register is 0 and writes are ignored. The read outputs therefore show 0 for any index.
- There is no X-propagation from unknown indices beyond what simulation gives naturally. All 4-bit index values are valid.

## Timing
- Write latency is 1 edge. The new value is visible on a read port immediately after the rising edge that commits it. The combinational path settles within the same cycle.
- Read latency is 0 cycles. An index change propagates to read_data with no clock involved.
- Read and write to the same index in the same cycle:
  - Before the edge, the read port shows the old value.
  - After the edge, it shows the new value.
  - There is no internal write-through bypass.
- Reset assertion (rst_n falling) clears all registers immediately, independent of clk. This includes reset mid-sequence.
- Reset deassertion is synchronous to the design's use. The first write can occur on the first rising edge with rst_n = 1.
- Reset values: all registers 0, so read_data1 = read_data2 = 16'h0000.

## Structure
- Shared package (cpu_pkg): DATA_W, ADDR_W and NUM_REGS constants, plus a reg_idx_t typedef (ADDR_W bits) and a word_t typedef (DATA_W bits) shared with decode and the ALU.
- Implementation is a single module: a register array, one always block with async reset for writes, and two continuous-assign read muxes.
- No sub-module is required. If synthesis prefers, the read mux can be factored into a small reg_read_mux sub-module that is instantiated twice.

## Test plan
- Reset: pulse rst_n low, then sweep read_reg1/read_reg2 over 0..15 → both read ports show 16'h0000 for every index.
- Fill and readback: with reg_write=1, write value i to register i for i=0..15, one per cycle. Then set reg_write=0 and sweep read_reg1=read_reg2=i → both outputs equal i.
- Write disable: set reg_write=0, write_reg=5, write_data=16'hBEEF and clock several edges → read of register 5 still returns 5.
- Same-cycle read/write: read_reg1=7 with write_reg=7, write_data=16'hA5A5, reg_write=1:
  - Before the edge, read_data1 = 7.
  - After the edge, read_data1 = 16'hA5A5.
- Dual port: write 16'h1234 to register 3 and 16'hFFFF to register 15, then set read_reg1=3 and read_reg2=15 in the same cycle → read_data1 = 16'h1234 and read_data2 = 16'hFFFF.
- Async reset mid-operation: after filling the registers, drop rst_n between clock edges → all reads return 0 immediately. A write attempted while rst_n=0 has no effect.
